// File: rtl/shift_seq_ctrl.sv
// Command sequencer for param_shift_direct_parallel_reg: one parallel load, then N shifts,
// optional ping-pong direction. Optional abort input when SHIFT_SEQ_ABORT_EN is defined.
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_pattern,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_dir,
    input  logic             cmd_bounce,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             we_n,
    output logic             direction,
    output logic [WIDTH-1:0] par_in,
    output logic             busy,
    output logic             done
);

    localparam int LEG_W = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
    localparam logic [LEG_W-1:0] LEG_MAX = LEG_W'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rem;
    logic [LEG_W-1:0] leg;
    logic             bounce;
    logic             accept;
    logic             abort_hit;
    logic             shift_step;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_hit = abort && (state == LOAD || state == SHIFT);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        shift_step = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                accept    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                if (abort_hit || rem == '0) state_nxt = DONE;
                else                        state_nxt = SHIFT;
            end
            SHIFT: begin
                shift_step = !abort_hit;
                if (abort_hit || rem == CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                // Back-to-back: a waiting command is taken at the edge closing DONE.
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_in    <= '0;
            direction <= 1'b0;
            rem       <= '0;
            leg       <= '0;
            bounce    <= 1'b0;
        end else if (accept) begin
            par_in    <= cmd_pattern;
            direction <= cmd_dir;
            rem       <= cmd_count;
            leg       <= '0;
            bounce    <= cmd_bounce;
        end else if (abort_hit) begin
            rem <= '0;
        end else if (shift_step) begin
            rem <= rem - CNT_W'(1);
            // A leg is WIDTH-1 shifts long; the light reaches the far end and turns.
            if (leg == LEG_MAX) begin
                leg <= '0;
                if (bounce) direction <= ~direction;
            end else begin
                leg <= leg + LEG_W'(1);
            end
        end
    end

    assign we_n      = (state != LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign cmd_ready = (state == IDLE) || (state == DONE);

endmodule
